vector_scalar_broadcast: RTL



---
 rtl/vector_scalar_broadcast_pkg.sv | 19 +
 rtl/vector_scalar_broadcast_sew_beat_replicate.sv | 53 +++++
 rtl/vector_scalar_broadcast.sv | 90 +++++++++
 3 files changed

// File: rtl/vector_scalar_broadcast_pkg.sv
// rtl/vector_scalar_broadcast_pkg.sv - shared encodings, defaults and FSM states for the scalar broadcaster
package vector_scalar_broadcast_pkg;

    localparam int VLEN_DEF = 256;
    localparam int DW_DEF   = 64;

    typedef enum logic [1:0] {
        VSEW_8  = 2'b00,
        VSEW_16 = 2'b01,
        VSEW_32 = 2'b10,
        VSEW_64 = 2'b11
    } vsew_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/vector_scalar_broadcast_sew_beat_replicate.sv
// rtl/vector_scalar_broadcast_sew_beat_replicate.sv - builds one tail-zeroed beat of a splatted scalar
module sew_beat_replicate
    import vector_scalar_broadcast_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int VL_W   = 6,
    parameter int BEAT_W = 2
) (
    input  logic [63:0]     value,
    input  vsew_e           vsew,
    input  logic [VL_W-1:0] vl,
    input  logic [BEAT_W-1:0] beat,
    output logic [DW-1:0]   beat_data
);

    logic [31:0] vl32;
    logic [31:0] beat32;

    assign vl32   = {{(32-VL_W){1'b0}}, vl};
    assign beat32 = {{(32-BEAT_W){1'b0}}, beat};

    // Element index of lane l is beat*(lanes per beat)+l; lanes at or past vl stay zero.
    always_comb begin
        beat_data = '0;
        case (vsew)
            VSEW_8: begin
                for (int l = 0; l < DW/8; l++) begin
                    if ((beat32 * 32'(DW/8) + 32'(l)) < vl32)
                        beat_data[l*8 +: 8] = value[7:0];
                end
            end
            VSEW_16: begin
                for (int l = 0; l < DW/16; l++) begin
                    if ((beat32 * 32'(DW/16) + 32'(l)) < vl32)
                        beat_data[l*16 +: 16] = value[15:0];
                end
            end
            VSEW_32: begin
                for (int l = 0; l < DW/32; l++) begin
                    if ((beat32 * 32'(DW/32) + 32'(l)) < vl32)
                        beat_data[l*32 +: 32] = value[31:0];
                end
            end
            default: begin
                for (int l = 0; l < DW/64; l++) begin
                    if ((beat32 * 32'(DW/64) + 32'(l)) < vl32)
                        beat_data[l*64 +: 64] = value;
                end
            end
        endcase
    end

endmodule

// File: rtl/vector_scalar_broadcast.sv
// rtl/vector_scalar_broadcast.sv - splats a scalar operand across a VLEN vector and streams it in DW beats
module vector_scalar_broadcast
    import vector_scalar_broadcast_pkg::*;
#(
    parameter int VLEN = VLEN_DEF,
    parameter int DW   = DW_DEF,
    localparam int BEATS  = VLEN / DW,
    localparam int VL_W   = $clog2(VLEN/8) + 1,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       dataA_64,
    input  logic [1:0]        vsew,
    input  logic [VL_W-1:0]   vl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [BEAT_W-1:0] out_beat,
    output logic              out_last
);

    state_e            state;
    logic [63:0]       cap_data;
    vsew_e             cap_vsew;
    logic [VL_W-1:0]   cap_vl;
    logic [BEAT_W-1:0] beat_cnt;
    logic [DW-1:0]     beat_data;
    logic              is_last;

    assign is_last = (beat_cnt == BEAT_W'(BEATS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            cap_data <= '0;
            cap_vsew <= VSEW_8;
            cap_vl   <= '0;
        end else if (flush) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cap_data <= dataA_64;
                        cap_vsew <= vsew_e'(vsew);
                        cap_vl   <= vl;
                        beat_cnt <= '0;
                        state    <= ST_BUSY;
                    end
                end
                default: begin
                    // Operands offered while busy are deliberately dropped, not queued.
                    if (out_ready) begin
                        if (is_last) begin
                            beat_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    sew_beat_replicate #(
        .DW     (DW),
        .VL_W   (VL_W),
        .BEAT_W (BEAT_W)
    ) u_replicate (
        .value     (cap_data),
        .vsew      (cap_vsew),
        .vl        (cap_vl),
        .beat      (beat_cnt),
        .beat_data (beat_data)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_BUSY);
    assign out_data  = out_valid ? beat_data : '0;
    assign out_beat  = beat_cnt;
    assign out_last  = out_valid && is_last;

endmodule
